seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_ctrl_if.sv | 13 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, hex segment patterns (a..g, a = MSB) and default timing.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam int DEF_N_DIGITS  = 4;
  localparam int DEF_SCAN_DIV  = 50000;
  localparam int DEF_BLANK_CYC = 500;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write bus between user logic (master) and the scan controller (slave).
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = 4
) ();

  logic                        wr_en;
  logic [$clog2(N_DIGITS)-1:0] wr_digit;
  logic [3:0]                  wr_data;

  modport master (output wr_en, output wr_digit, output wr_data);
  modport slave  (input  wr_en, input  wr_digit, input  wr_data);

endinterface

// File: rtl/seg7_decode.sv
// Hex value to a..g segment pattern, purely combinational.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  assign seg = SEG_PAT[val];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-cathode seven-segment scan controller with a blanking
// gap per slot. Define SEG7_LZ_BLANK_EN to suppress leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  seg7_scan_ctrl_if.slave      wr,
  output logic [N_DIGITS-1:0]  an,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 e,
  output logic                 f,
  output logic                 g
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]  data_q, data_d;
  logic [3:0]                shown_q, shown_d;
  logic [N_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic [6:0]                dec_seg;

  // Decoding the next shown value lets the pattern register load on the slot-entry edge.
  seg7_decode u_decode (
    .val (shown_d),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      shown_q <= '0;
      an_q    <= '1;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      shown_q <= shown_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    data_d = data_q;
    if (wr.wr_en && (int'(wr.wr_digit) < N_DIGITS)) begin
      data_d[wr.wr_digit] = wr.wr_data;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shown_d = shown_q;

    if (!enable) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          // Same-edge write to this digit is captured via data_d.
          if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = DRIVE;
            shown_d = data_d[idx_q];
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pin registers load once at slot entry and hold for the whole DRIVE slot.
  always_comb begin
`ifdef SEG7_LZ_BLANK_EN
    logic lz_blank;
`endif
    an_d  = '1;
    seg_d = '0;
    if (state_d == DRIVE) begin
      if (state_q == DRIVE) begin
        an_d  = an_q;
        seg_d = seg_q;
      end else begin
        an_d[idx_d] = 1'b0;
        seg_d       = dec_seg;
`ifdef SEG7_LZ_BLANK_EN
        lz_blank = (idx_q != '0) && (shown_d == 4'h0);
        for (int k = 0; k < N_DIGITS; k++) begin
          if ((k > int'(idx_q)) && (data_d[k] != 4'h0)) begin
            lz_blank = 1'b0;
          end
        end
        if (lz_blank) begin
          an_d = '1;
        end
`endif
      end
    end
  end

  assign an                  = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] an;
  logic       a, b, c, d, e, f, g;

  int checks   = 0;
  int failures = 0;

  seg7_scan_ctrl_if #(.N_DIGITS(N)) wr_if ();

  seg7_scan_ctrl #(
    .N_DIGITS  (N),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .wr     (wr_if.slave),
    .an     (an),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .e      (e),
    .f      (f),
    .g      (g)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'h0: pat = 7'b1111110;  4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;  4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;  4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;  4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;  4'h9: pat = 7'b1111011;
      4'hA: pat = 7'b1110111;  4'hB: pat = 7'b0011111;
      4'hC: pat = 7'b1001110;  4'hD: pat = 7'b0111101;
      4'hE: pat = 7'b1001111;  default: pat = 7'b1000111;
    endcase
  endfunction

  // Reference: k = enabled edges since scan (re)start; snap = digit values at slot entry.
  int         k;
  logic [3:0] md   [N];
  logic [3:0] snap [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0;
      for (int i = 0; i < N; i++) begin
        md[i]   = 4'h0;
        snap[i] = 4'h0;
      end
    end else begin
      if (wr_if.wr_en) md[wr_if.wr_digit] = wr_if.wr_data;
      if (!enable) k = 0;
      else         k = k + 1;
      if (k > 0 && (k % FRAME) % SD == BC) begin
        for (int i = 0; i < N; i++) snap[i] = md[i];
      end
    end
  end

  function automatic bit m_drive();
    return (k > 0) && ((k % FRAME) % SD >= BC);
  endfunction

  function automatic int m_slot();
    return (k % FRAME) / SD;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    int         s;
    bit         zero_up;
    one = 4'b0001;
    if (!m_drive()) return 4'hF;
    s = m_slot();
    zero_up = 1'b1;
    for (int j = s; j < N; j++) if (snap[j] != 4'h0) zero_up = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (s != 0 && zero_up) return 4'hF;
`endif
    return ~(one << s);
  endfunction

  function automatic logic [6:0] exp_seg();
    if (!m_drive()) return 7'b0;
    return pat(snap[m_slot()]);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("model_an", {3'b0, an}, {3'b0, exp_an()});
      check("model_seg", {a, b, c, d, e, f, g}, exp_seg());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check({nm, "_an"}, {3'b0, an}, {3'b0, an_exp});
    check({nm, "_seg"}, {a, b, c, d, e, f, g}, seg_exp);
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_digit = '0;
    wr_if.wr_data  = 4'h0;

    // Reset held, then released with no writes
    cyc(3);
    lit("in_reset", 4'hF, 7'b0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    lit("edge1_dark", 4'hF, 7'b0);
    cyc(1);
    lit("edge2_d0_zero", 4'b1110, 7'b1111110);
    cyc(6);
    lit("edge8_gap", 4'hF, 7'b0);
    cyc(FRAME);

    // Write 1..4 into digits 0..3 while held dark
    reset = 1'b1;
    cyc(1);
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_if.wr_en    = 1'b1;
      wr_if.wr_digit = 2'(i);
      wr_if.wr_data  = 4'(i + 1);
      cyc(1);
    end
    wr_if.wr_en = 1'b0;
    enable      = 1'b1;
    cyc(2);
    lit("d0_one", 4'b1110, 7'b0110000);
    cyc(8);
    lit("d1_two", 4'b1101, 7'b1101101);
    cyc(16);
    lit("d3_four", 4'b0111, 7'b0110011);

    // Mid-slot write of digit 0 on the third DRIVE cycle of its next slot
    cyc(10);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_digit = 2'd0;
    wr_if.wr_data  = 4'h8;
    cyc(1);
    wr_if.wr_en = 1'b0;
    cyc(1);
    lit("midwrite_old", 4'b1110, 7'b0110000);
    cyc(28);
    lit("midwrite_new", 4'b1110, 7'b1111111);

    // Enable dropped during digit 2's slot
    cyc(17);
    lit("d2_before_drop", 4'b1011, 7'b1111001);
    enable = 1'b0;
    cyc(1);
    lit("enable_low", 4'hF, 7'b0);
    cyc(2);
    enable = 1'b1;
    cyc(1);
    lit("restart_dark", 4'hF, 7'b0);
    cyc(1);
    lit("restart_d0", 4'b1110, 7'b1111111);

    // Asynchronous reset between edges while driving
    reset = 1'b1;
    #1;
    lit("async_reset", 4'hF, 7'b0);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    lit("cleared_d0", 4'b1110, 7'b1111110);
    cyc(8);
    lit("cleared_d1", 4'b1101, 7'b1111110);

    // Digits 3..0 = 0,0,5,0
    reset = 1'b1;
    cyc(1);
    reset          = 1'b0;
    enable         = 1'b0;
    wr_if.wr_en    = 1'b1;
    wr_if.wr_digit = 2'd1;
    wr_if.wr_data  = 4'h5;
    cyc(1);
    wr_if.wr_en = 1'b0;
    enable      = 1'b1;
    cyc(2);
    lit("lz_d0", 4'b1110, 7'b1111110);
    cyc(8);
    lit("lz_d1", 4'b1101, 7'b1011011);
    cyc(8);
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d2_an", {3'b0, an}, 7'b0001111);
`else
    check("lz_d2_an", {3'b0, an}, 7'b0001011);
`endif
    cyc(8);
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d3_an", {3'b0, an}, 7'b0001111);
`else
    check("lz_d3_an", {3'b0, an}, 7'b0000111);
`endif
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
